// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the pipeline sequencing controller.
// Purpose : state encoding and default drain length. The debug unit imports
//           this package to decode the controller state.
// Ports   : none (package).
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } hcu_state_t;

  // HALT needs three more advances after entering DRAIN to leave WB.
  localparam int DRAIN_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/hazard_control_unit_hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Purpose : flags when the ID instruction reads a register that the load now
//           in EX has not written back yet.
// Ports   : id_rs, id_rt, id_uses_rt  - source operands of the ID instruction
//           ex_mem_read, ex_write_reg - load flag and destination of EX
//           load_use                  - stall request
module hazard_detect
  import hazard_control_unit_pkg::*;
#(
  parameter int NB = 5
) (
  input  logic [NB-1:0] id_rs,
  input  logic [NB-1:0] id_rt,
  input  logic          id_uses_rt,
  input  logic          ex_mem_read,
  input  logic [NB-1:0] ex_write_reg,
  output logic          load_use
);

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign load_use = ex_mem_read && (ex_write_reg != '0) &&
                    ((ex_write_reg == id_rs) ||
                     (id_uses_rt && (ex_write_reg == id_rt)));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller for the 5-stage core.
// Purpose : drives the pipeline register enables and flushes, stalls on
//           load-use, flushes on taken branches / jumps, drains the pipeline
//           on HALT, gates advance in debug single-step mode, and counts
//           advancing and stall cycles.
// Ports   : clk, reset (sync, active-high)
//           debug_mode, step_pulse               - single-step control
//           id_rs, id_rt, id_uses_rt             - ID operand info
//           ex_mem_read, ex_write_reg            - EX load info
//           jump_id, branch_taken_mem, halt_id   - control-flow events
//           stage_enable, pc_write, ifid_write   - advance enables
//           ifid_flush, idex_flush, exmem_flush  - stage flushes
//           halted, cycle_count, stall_count     - status for the debug unit
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | normal issue
// ST_DRAIN   | HALT passed ID; fetch frozen, older instructions retire
// ST_HALTED  | pipeline empty and stopped; only reset leaves
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int len          = 32,
  parameter int NB           = $clog2(len),
  parameter int drain_cycles = DRAIN_CYCLES_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           debug_mode,
  input  logic           step_pulse,
  input  logic [NB-1:0]  id_rs,
  input  logic [NB-1:0]  id_rt,
  input  logic           id_uses_rt,
  input  logic           ex_mem_read,
  input  logic [NB-1:0]  ex_write_reg,
  input  logic           jump_id,
  input  logic           branch_taken_mem,
  input  logic           halt_id,
  output logic           stage_enable,
  output logic           pc_write,
  output logic           ifid_write,
  output logic           ifid_flush,
  output logic           idex_flush,
  output logic           exmem_flush,
  output logic           halted,
  output logic [len-1:0] cycle_count,
  output logic [len-1:0] stall_count
);

  localparam int DW = $clog2(drain_cycles + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(drain_cycles - 1);

  hcu_state_t    state;
  logic [DW-1:0] drain_cnt;
  logic          load_use;
  logic          adv;

  hazard_detect #(.NB(NB)) u_hazard_detect (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_write_reg (ex_write_reg),
    .load_use     (load_use)
  );

  assign adv = !reset && (state != ST_HALTED) && (!debug_mode || step_pulse);

  always_comb begin
    stage_enable = 1'b0;
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    halted       = 1'b0;
    if (reset) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (state == ST_HALTED) begin
      halted = 1'b1;
    end else if (adv) begin
      stage_enable = 1'b1;
      if (branch_taken_mem) begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (state == ST_DRAIN) begin
        // Keep flushing IF/ID so the HALT is never reissued.
        ifid_flush = 1'b1;
        idex_flush = load_use;
      end else if (load_use) begin
        idex_flush = 1'b1;
      end else if (halt_id) begin
        // HALT moves on to EX; fetch stops here.
        ifid_write = 1'b1;
      end else if (jump_id) begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      drain_cnt   <= '0;
      cycle_count <= '0;
      stall_count <= '0;
    end else if (adv) begin
      cycle_count <= cycle_count + 1'b1;
      if (branch_taken_mem) begin
        // A HALT being drained was on the wrong path.
        state     <= ST_RUN;
        drain_cnt <= '0;
      end else if (load_use) begin
        stall_count <= stall_count + 1'b1;
      end else if (state == ST_DRAIN) begin
        if (drain_cnt == DRAIN_LAST) begin
          state <= ST_HALTED;
        end else begin
          drain_cnt <= drain_cnt + 1'b1;
        end
      end else if (halt_id) begin
        state     <= ST_DRAIN;
        drain_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  localparam int LEN = 32;
  localparam int NBW = 5;

  // Control vector order: stage_enable, pc_write, ifid_write,
  // ifid_flush, idex_flush, exmem_flush, halted
  localparam logic [6:0] C_NORM  = 7'b1110000;
  localparam logic [6:0] C_RST   = 7'b0001110;
  localparam logic [6:0] C_STALL = 7'b1000100;
  localparam logic [6:0] C_BR    = 7'b1111110;
  localparam logic [6:0] C_JMP   = 7'b1111000;
  localparam logic [6:0] C_HIN   = 7'b1010000;
  localparam logic [6:0] C_DRN   = 7'b1001000;
  localparam logic [6:0] C_DRNLU = 7'b1001100;
  localparam logic [6:0] C_HLT   = 7'b0000001;
  localparam logic [6:0] C_PAUSE = 7'b0000000;

  logic clk = 1'b0;
  logic reset;
  logic debug_mode, step_pulse;
  logic [NBW-1:0] id_rs, id_rt, ex_write_reg;
  logic id_uses_rt, ex_mem_read, jump_id, branch_taken_mem, halt_id;
  logic stage_enable, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, halted;
  logic [LEN-1:0] cycle_count, stall_count;

  typedef struct {
    string          tag;
    logic [6:0]     ctl;
    logic [LEN-1:0] cyc;
    logic [LEN-1:0] stl;
  } exp_t;

  exp_t exp_q[$];
  logic [LEN-1:0] exp_cyc, exp_stl;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.len(LEN), .drain_cycles(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .debug_mode       (debug_mode),
    .step_pulse       (step_pulse),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_uses_rt       (id_uses_rt),
    .ex_mem_read      (ex_mem_read),
    .ex_write_reg     (ex_write_reg),
    .jump_id          (jump_id),
    .branch_taken_mem (branch_taken_mem),
    .halt_id          (halt_id),
    .stage_enable     (stage_enable),
    .pc_write         (pc_write),
    .ifid_write       (ifid_write),
    .ifid_flush       (ifid_flush),
    .idex_flush       (idex_flush),
    .exmem_flush      (exmem_flush),
    .halted           (halted),
    .cycle_count      (cycle_count),
    .stall_count      (stall_count)
  );

  task automatic clear_inputs();
    reset = 1'b0; debug_mode = 1'b0; step_pulse = 1'b0;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_write_reg = '0;
    jump_id = 1'b0; branch_taken_mem = 1'b0; halt_id = 1'b0;
  endtask

  // Push the expectation for the current cycle, compare at the negedge,
  // then step the bench-side counter model across the next edge.
  task automatic chk(input string tag, input logic [6:0] c, input int stall_inc,
                     input bit rst_next);
    exp_t e;
    logic [6:0] obs;
    e.tag = tag; e.ctl = c; e.cyc = exp_cyc; e.stl = exp_stl;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    obs = {stage_enable, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, halted};
    n_tests++;
    assert (obs === e.ctl) else begin
      n_fail++;
      $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs, e.ctl);
    end
    n_tests++;
    assert (cycle_count === e.cyc) else begin
      n_fail++;
      $error("FAIL %s cycle_count observed=%0d expected=%0d", e.tag, cycle_count, e.cyc);
    end
    n_tests++;
    assert (stall_count === e.stl) else begin
      n_fail++;
      $error("FAIL %s stall_count observed=%0d expected=%0d", e.tag, stall_count, e.stl);
    end
    if (rst_next) begin
      exp_cyc = '0;
      exp_stl = '0;
    end else begin
      if (c[6]) exp_cyc = exp_cyc + 1;
      exp_stl = exp_stl + LEN'(stall_inc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    exp_cyc = '0;
    exp_stl = '0;
    @(posedge clk);
    #1;
    chk("reset", C_RST, 0, 1);
    clear_inputs();
    chk("run0", C_NORM, 0, 0);
    chk("run1", C_NORM, 0, 0);

    // load-use on rs
    ex_mem_read = 1'b1; ex_write_reg = 5'd5; id_rs = 5'd5;
    chk("lu_rs", C_STALL, 1, 0);
    clear_inputs();
    chk("after_lu", C_NORM, 0, 0);
    // load-use on rt
    ex_mem_read = 1'b1; ex_write_reg = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd3;
    chk("lu_rt", C_STALL, 1, 0);
    id_uses_rt = 1'b0;
    chk("rt_unused", C_NORM, 0, 0);
    // register 0 never stalls
    clear_inputs();
    ex_mem_read = 1'b1; ex_write_reg = 5'd0; id_rs = 5'd0;
    chk("lu_r0", C_NORM, 0, 0);
    // no load, matching register
    clear_inputs();
    ex_write_reg = 5'd9; id_rs = 5'd9;
    chk("no_load", C_NORM, 0, 0);

    // branch beats load-use and jump
    clear_inputs();
    ex_mem_read = 1'b1; ex_write_reg = 5'd5; id_rs = 5'd5; jump_id = 1'b1; branch_taken_mem = 1'b1;
    chk("br_prio", C_BR, 0, 0);
    clear_inputs();
    jump_id = 1'b1;
    chk("jump", C_JMP, 0, 0);

    // HALT drain
    clear_inputs();
    halt_id = 1'b1;
    chk("halt_in", C_HIN, 0, 0);
    clear_inputs();
    repeat (3) chk("drain", C_DRN, 0, 0);
    repeat (10) chk("halted", C_HLT, 0, 0);
    debug_mode = 1'b1; step_pulse = 1'b1;
    chk("halted_step", C_HLT, 0, 0);
    clear_inputs();
    repeat (9) chk("halted2", C_HLT, 0, 0);

    // reset out of HALTED
    reset = 1'b1;
    chk("reset2", C_RST, 0, 1);
    clear_inputs();
    chk("run_after_rst", C_NORM, 0, 0);

    // wrong-path HALT
    halt_id = 1'b1;
    chk("wp_halt", C_HIN, 0, 0);
    clear_inputs();
    branch_taken_mem = 1'b1;
    chk("wp_branch", C_BR, 0, 0);
    clear_inputs();
    repeat (5) chk("wp_run", C_NORM, 0, 0);

    // load-use while draining holds the drain counter
    halt_id = 1'b1;
    chk("lud_halt", C_HIN, 0, 0);
    clear_inputs();
    ex_mem_read = 1'b1; ex_write_reg = 5'd4; id_rs = 5'd4;
    chk("lud_stall", C_DRNLU, 1, 0);
    clear_inputs();
    repeat (3) chk("lud_drain", C_DRN, 0, 0);
    chk("lud_halted", C_HLT, 0, 0);
    reset = 1'b1;
    chk("reset3", C_RST, 0, 1);

    // debug single-step
    clear_inputs();
    debug_mode = 1'b1;
    repeat (10) chk("dbg_pause", C_PAUSE, 0, 0);
    step_pulse = 1'b1;
    repeat (3) chk("dbg_step", C_NORM, 0, 0);
    step_pulse = 1'b0;
    chk("dbg_pause2", C_PAUSE, 0, 0);
    clear_inputs();
    chk("dbg_exit", C_NORM, 0, 0);

    // reset mid-drain
    halt_id = 1'b1;
    chk("md_halt", C_HIN, 0, 0);
    clear_inputs();
    chk("md_drain", C_DRN, 0, 0);
    reset = 1'b1;
    chk("md_reset", C_RST, 0, 1);
    clear_inputs();
    repeat (5) chk("md_run", C_NORM, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
